// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage: single-cycle multiply,
// 32-step restoring divide with a sign-fix cycle. Optional macro: EX_MULDIV_DIV_FASTPATH_EN.
module ex_muldiv_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic [31:0] o_result,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_stall
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quot_q, rem_q;
  logic [31:0] result_q;
  logic [5:0]  cnt_q;

  logic        accept;
  logic        fast_special;
  logic [31:0] a_mag_in;

  assign accept   = (state_q == IDLE) && i_start && !i_flush;
  assign a_mag_in = (i_funct3[2] && !i_funct3[0] && i_rs1_data[31]) ? (~i_rs1_data + 32'd1)
                                                                      : i_rs1_data;

`ifdef EX_MULDIV_DIV_FASTPATH_EN
  assign fast_special = i_funct3[2] &&
                        ((i_rs2_data == '0) ||
                         (!i_funct3[0] && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == '1)));
`else
  assign fast_special = 1'b0;
`endif

  // Multiply: 33-bit extended operands; only the low 64 product bits are ever needed.
  logic        a_sx, b_sx;
  logic [63:0] a64, b64, prod;
  logic [31:0] mul_res;

  always_comb begin
    a_sx    = ((funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10)) && a_q[31];
    b_sx    = (funct3_q[1:0] == 2'b01) && b_q[31];
    a64     = {{32{a_sx}}, a_q};
    b64     = {{32{b_sx}}, b_q};
    prod    = a64 * b64;
    mul_res = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // Restoring divide step: {rem, quot} shifts left, quot doubles as the dividend register.
  logic        div_signed;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next, quot_next;

  always_comb begin
    div_signed = !funct3_q[0];
    b_mag      = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
    shifted    = {rem_q, quot_q[31]};
    fits       = shifted >= {1'b0, b_mag};
    rem_next   = fits ? 32'(shifted - {1'b0, b_mag}) : shifted[31:0];
    quot_next  = {quot_q[30:0], fits};
  end

  logic        is_rem, div_zero, div_ovf;
  logic [31:0] q_fix, r_fix, fix_res;

  always_comb begin
    is_rem   = funct3_q[1];
    div_zero = (b_q == '0);
    div_ovf  = div_signed && (a_q == 32'h8000_0000) && (b_q == '1);
    q_fix    = (div_signed && (a_q[31] ^ b_q[31])) ? (~quot_q + 32'd1) : quot_q;
    r_fix    = (div_signed && a_q[31]) ? (~rem_q + 32'd1) : rem_q;
    if (div_zero) begin
      fix_res = is_rem ? a_q : '1;
    end else if (div_ovf) begin
      fix_res = is_rem ? '0 : 32'h8000_0000;
    end else begin
      fix_res = is_rem ? r_fix : q_fix;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!i_funct3[2])     state_d = MUL;
          else if (fast_special) state_d = FIX;
          else                  state_d = DIV;
        end
      end
      MUL:  state_d = DONE;
      DIV:  if (cnt_q == 6'd31) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= i_funct3;
        a_q      <= i_rs1_data;
        b_q      <= i_rs2_data;
        quot_q   <= a_mag_in;
        rem_q    <= '0;
        cnt_q    <= '0;
      end
      unique case (state_q)
        MUL: if (!i_flush) result_q <= mul_res;
        DIV: begin
          quot_q <= quot_next;
          rem_q  <= rem_next;
          cnt_q  <= cnt_q + 6'd1;
        end
        FIX: if (!i_flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign o_result = result_q;
  assign o_done   = (state_q == DONE);
  assign o_busy   = (state_q != IDLE);
  assign o_stall  = !i_rst && (accept || (state_q == MUL) || (state_q == DIV) || (state_q == FIX));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed, randomized, flush and reset scenarios
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [31:0] o_result;
  logic        o_done, o_busy, o_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_funct3   (f3),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_flush    (flush),
    .o_result   (o_result),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_stall    (o_stall)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
`ifdef EX_MULDIV_DIV_FASTPATH_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
    return 34;
  endfunction

  // Drives one instruction the way the pipeline would (start held until done),
  // scrambling operands after acceptance; reports result, latency and stall cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    @(negedge clk);
    start = 1'b1; f3 = op; rs1 = a; rs2 = b;
    #1;
    stalls = int'(o_stall);
    lat    = -1;
    res    = 'x;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      stalls += int'(o_stall);
      if (o_done) begin
        res = o_result;
        lat = k;
        break;
      end
      rs1 = $urandom;
      rs2 = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; flush = 1'b0; f3 = 3'd4; rs1 = 32'd9; rs2 = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (o_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", o_result); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", o_stall); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [14] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [14] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678,
                              32'h8000_0000, 32'h0000_0000};
    logic [31:0] res;
    int          lat, stalls, want_lat;
    for (int i = 0; i < 14; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, stalls);
      want_lat = exp_lat(ops[i], as[i], bs[i]);
      n_tests++; if (res !== exp[i]) begin n_fail++; $display("FAIL directed_result[%0d] got %h want %h", i, res, exp[i]); end
      n_tests++; if (lat != want_lat) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, want_lat); end
      n_tests++; if (stalls != want_lat) begin n_fail++; $display("FAIL directed_stalls[%0d] got %0d want %0d", i, stalls, want_lat); end
    end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b, res, want;
    int          lat, stalls, want_lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(op, a, b, res, lat, stalls);
      want     = ref_result(op, a, b);
      want_lat = exp_lat(op, a, b);
      n_tests++; if (res !== want) begin n_fail++; $display("FAIL random_result op=%0d a=%h b=%h got %h want %h", op, a, b, res, want); end
      n_tests++; if (lat != want_lat) begin n_fail++; $display("FAIL random_latency op=%0d got %0d want %0d", op, lat, want_lat); end
      n_tests++; if (stalls != want_lat) begin n_fail++; $display("FAIL random_stalls op=%0d got %0d want %0d", op, stalls, want_lat); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev, res;
    int          lat;
    bit          early_done;
    prev       = o_result;
    early_done = 0;
    @(negedge clk);
    start = 1'b1; f3 = 3'd4; rs1 = $urandom; rs2 = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_done) early_done = 1;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    n_tests++; if (early_done || o_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %b want 0", early_done | o_done); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", o_busy); end
    n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", o_stall); end
    n_tests++; if (o_result !== prev) begin n_fail++; $display("FAIL flush_result_hold got %h want %h", o_result, prev); end
    start = 1'b1; f3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
    #1;
    n_tests++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL flush_restart_stall got %b want 1", o_stall); end
    @(posedge clk);
    lat = -1; res = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_done) begin lat = k; res = o_result; break; end
    end
    start = 1'b0;
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL flush_restart_latency got %0d want 2", lat); end
    n_tests++; if (res !== 32'd30) begin n_fail++; $display("FAIL flush_restart_result got %h want 0000001e", res); end
  endtask

  task automatic test_reset_mid;
    bit leaked;
    @(negedge clk);
    start = 1'b1; f3 = 3'd4; rs1 = $urandom; rs2 = 32'd5;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (o_result !== 32'd0) begin n_fail++; $display("FAIL midreset_result got %h want 00000000", o_result); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", o_busy); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", o_done); end
    n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall got %b want 0", o_stall); end
    rst = 1'b0; flush = 1'b1; start = 1'b1;
    leaked = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (o_busy || o_stall) leaked = 1;
      @(negedge clk);
    end
    n_tests++; if (leaked) begin n_fail++; $display("FAIL flush_blocks_start got busy/stall 1 want 0"); end
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; rs1 = '0; rs2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide execution unit in the EX stage. It consumes the post-forwarding operands, i.e. the outputs of the EX operand muxes steered by the forwarding controls. It computes all eight M-extension operations. It stalls the pipeline front end until the result is ready, then presents the result for one cycle so the instruction advances into EX/MEM.

## Interface
Parameters:
- none (data width fixed at 32)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  EX holds a valid M-extension instruction
- i_funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_data  input  32  forwarded operand A (dividend / multiplicand)
- i_rs2_data  input  32  forwarded operand B (divisor / multiplier)
- i_flush  input  1  kill in-flight operation (branch/exception flush of EX)
- o_result  output  32  registered result; holds until the next completion
- o_done  output  1  one-cycle pulse; o_result valid this cycle
- o_busy  output  1  FSM not in IDLE
- o_stall  output  1  freeze PC/IF/ID/ID-EX this cycle

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - i_start & !i_flush latches operands and funct3.
  - funct3[2]=0 goes to MUL; funct3[2]=1 goes to DIV.
  - With EX_MULDIV_DIV_FASTPATH_EN and a special case (see Configuration), goes straight to FIX.
- MUL: one cycle.
  - Forms the 64-bit product of the 33-bit sign/zero-extended operands. MULH/MULHSU sign-extend A; MULH sign-extends B; the others zero-extend.
  - MUL selects product[31:0]; the other multiplies select product[63:32]. Result registered, then go to DONE.
- DIV: 32 restoring iterations on magnitudes.
  - Magnitudes are |A|, |B| for signed ops; raw values for unsigned ops.
  - 6-bit counter 0..31; one quotient bit per cycle, MSB first. After count 31, go to FIX.
- FIX: one cycle of sign correction.
  - Quotient is negated if sign(A)^sign(B), signed ops only.
  - Remainder takes sign(A), signed ops only.
  - Overrides, applied in both configurations:
    - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
    - DIV with A=0x80000000, B=0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
  - Go to DONE.
- DONE: o_done=1, o_result valid. Always go to IDLE next cycle.
  - i_start is ignored here, since it still reflects the retiring instruction.
- o_busy = (state != IDLE).
- o_stall = (IDLE & i_start & !i_flush) | MUL | DIV | FIX. It is low in DONE, so the instruction leaves EX at the end of DONE.
- i_flush in any non-IDLE state goes to IDLE next cycle. No o_done is produced and o_result is unchanged.
- i_flush has priority over i_start.
- Reset values:
  - state IDLE
  - o_result 0x00000000
  - o_done 0, o_busy 0
  - o_stall 0 (i_start is ignored while i_rst is high)
  - counter 0
- Reset mid-operation aborts it identically to a flush, and also clears o_result.

## Timing
- Start accepted in cycle N (IDLE & i_start).
- MUL*: MUL state at N+1, o_done at N+2. o_stall is high in N and N+1.
- DIV*/REM*: DIV states N+1..N+32, FIX at N+33, o_done at N+34. o_stall is high N..N+33.
- Fast path (macro defined, special case only): FIX at N+1, o_done at N+2.
- Back-to-back: the earliest next acceptance is DONE+1.
- Operand inputs are sampled only in the accept cycle; later changes have no effect.

## Configuration
- EX_MULDIV_DIV_FASTPATH_EN:
  - Defined: division with divisor 0, or signed overflow (A=0x80000000, B=-1, DIV/REM), skips the DIV iterations. Latency is 2 cycles.
  - Undefined: every divide/remainder takes 34 cycles.
- Results are bit-identical in both configurations.

## Test plan
- MUL, A=7, B=-3 (0xFFFFFFFD) -> o_done at N+2, o_result 0xFFFFFFEB; o_stall high exactly 2 cycles.
- MULH / MULHSU / MULHU, A=0x80000000, B=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV, A=-7, B=2 -> 0xFFFFFFFD at N+34; REM, same operands -> 0xFFFFFFFF; DIVU, 100/7 -> 14; REMU -> 2.
- DIV by zero, A=0x12345678, B=0 -> DIV 0xFFFFFFFF, REM 0x12345678. Overflow DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Done at N+2 with the macro, N+34 without.
- DIV started, i_flush at N+10 -> IDLE at N+11, o_stall low, no o_done, o_result keeps its prior value. Then a new MUL accepted at N+11 completes normally.
- i_rst asserted at N+5 of a DIV -> next cycle o_result 0, o_busy 0, o_done 0. i_start held with i_flush high in IDLE -> never accepted.
